// File: rtl/gol_gen_buffer_pkg.sv
// Shared types and helpers for the double-buffered Game of Life generation store.
package gol_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, SWAP} gol_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROWS  = 8;
  localparam int MAX_WIDTH = 64;

  // Returns {R, row, L} in the low width+2 bits; toroidal mode wraps the edge columns.
  function automatic logic [MAX_WIDTH+1:0] guard_row(input logic [MAX_WIDTH-1:0] row,
                                                     input int width, input bit wrap);
    logic [MAX_WIDTH+1:0] g;
    g = {2'b00, row} << 1;
    if (wrap) begin
      g[0] = |(row & (MAX_WIDTH'(1) << (width - 1)));
      g = g | ((MAX_WIDTH+2)'(row[0]) << (width + 1));
    end
    return g;
  endfunction

endpackage

// File: rtl/gol_gen_buffer_if.sv
// Seed, window-stream and next-generation write bundle of the generation buffer.
interface gol_gen_buffer_if #(
  parameter int WIDTH   = 8,
  parameter int ROWBITS = 3,
  parameter int GENBITS = 16
);
  logic               load_en;
  logic [ROWBITS-1:0] load_addr;
  logic [WIDTH-1:0]   load_data;
  logic               start;
  logic               win_valid;
  logic               win_ready;
  logic [ROWBITS-1:0] win_row;
  logic [WIDTH+1:0]   win_above;
  logic [WIDTH+1:0]   win_cur;
  logic [WIDTH+1:0]   win_below;
  logic               nxt_we;
  logic [ROWBITS-1:0] nxt_addr;
  logic [WIDTH-1:0]   nxt_data;
  logic               busy;
  logic               done;
  logic [GENBITS-1:0] gen_count;

  modport master (
    input  load_en, load_addr, load_data, start, win_ready, nxt_we, nxt_addr, nxt_data,
    output win_valid, win_row, win_above, win_cur, win_below, busy, done, gen_count
  );

  modport slave (
    output load_en, load_addr, load_data, start, win_ready, nxt_we, nxt_addr, nxt_data,
    input  win_valid, win_row, win_above, win_cur, win_below, busy, done, gen_count
  );
endinterface

// File: rtl/gol_row_bank.sv
// One generation of cell rows: single write port, three combinational read ports.
module gol_row_bank #(
  parameter int WIDTH   = 8,
  parameter int ROWS    = 8,
  parameter int ROWBITS = 3
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               we,
  input  logic [ROWBITS-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [ROWBITS-1:0] raddr_a,
  input  logic [ROWBITS-1:0] raddr_c,
  input  logic [ROWBITS-1:0] raddr_b,
  output logic [WIDTH-1:0]   rdata_a,
  output logic [WIDTH-1:0]   rdata_c,
  output logic [WIDTH-1:0]   rdata_b
);

  logic [WIDTH-1:0] mem [ROWS];

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_c = mem[raddr_c];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/gol_gen_buffer.sv
// Double-buffered generation store: scans 3-row windows out of the current bank
// while the next generation is collected in the shadow bank, then swaps.
module gol_gen_buffer
  import gol_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ROWS    = DEF_ROWS,
  parameter int ROWBITS = $clog2(ROWS),
  parameter int WRAP    = 0,
  parameter int GENBITS = 16
) (
  input logic             ph2,
  input logic             reset,
  gol_gen_buffer_if.master bus
);

  localparam logic [ROWBITS-1:0] LAST_ROW = ROWBITS'(ROWS - 1);
  localparam logic [ROWBITS:0]   ROWS_W   = (ROWBITS+1)'(ROWS);

  gol_state_e         state, state_nxt;
  logic [ROWBITS-1:0] scan_row, scan_row_nxt;
  logic [ROWS-1:0]    mask, mask_nxt, mask_set;
  logic               cur_sel, cur_sel_nxt;
  logic [GENBITS-1:0] gen_cnt, gen_cnt_nxt;

  logic               load_ok, nxt_ok;
  logic [ROWBITS-1:0] wr_addr, above_addr, below_addr;
  logic [WIDTH-1:0]   wr_data, raw_above, raw_below;
  logic [WIDTH-1:0]   rd_a [2];
  logic [WIDTH-1:0]   rd_c [2];
  logic [WIDTH-1:0]   rd_b [2];

  assign load_ok  = (state == IDLE) && bus.load_en && ({1'b0, bus.load_addr} < ROWS_W);
  assign nxt_ok   = ((state == SCAN) || (state == DRAIN)) && bus.nxt_we
                    && ({1'b0, bus.nxt_addr} < ROWS_W);
  assign mask_set = nxt_ok ? (ROWS'(1) << bus.nxt_addr) : '0;
  assign wr_addr  = load_ok ? bus.load_addr : bus.nxt_addr;
  assign wr_data  = load_ok ? bus.load_data : bus.nxt_data;

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      scan_row <= '0;
      mask     <= '0;
      cur_sel  <= 1'b0;
      gen_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      scan_row <= scan_row_nxt;
      mask     <= mask_nxt;
      cur_sel  <= cur_sel_nxt;
      gen_cnt  <= gen_cnt_nxt;
    end
  end

  // The drain exit looks at the mask including a write landing this cycle.
  always_comb begin
    state_nxt    = state;
    scan_row_nxt = scan_row;
    mask_nxt     = mask | mask_set;
    cur_sel_nxt  = cur_sel;
    gen_cnt_nxt  = gen_cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          scan_row_nxt = '0;
          mask_nxt     = '0;
          state_nxt    = SCAN;
        end
      end
      SCAN: begin
        if (bus.win_ready) begin
          if (scan_row == LAST_ROW) state_nxt = DRAIN;
          else                      scan_row_nxt = scan_row + 1'b1;
        end
      end
      DRAIN: begin
        if (&mask_nxt) state_nxt = SWAP;
      end
      SWAP: begin
        cur_sel_nxt = ~cur_sel;
        gen_cnt_nxt = gen_cnt + 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Seed loads target the current bank, next-generation writes the other one.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel_here;
    assign sel_here = (cur_sel == 1'(b));
    gol_row_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .ROWBITS(ROWBITS)) u_bank (
      .ph2     (ph2),
      .reset   (reset),
      .we      ((load_ok && sel_here) || (nxt_ok && !sel_here)),
      .waddr   (wr_addr),
      .wdata   (wr_data),
      .raddr_a (above_addr),
      .raddr_c (scan_row),
      .raddr_b (below_addr),
      .rdata_a (rd_a[b]),
      .rdata_c (rd_c[b]),
      .rdata_b (rd_b[b])
    );
  end

  assign above_addr = (scan_row == '0) ? LAST_ROW : scan_row - 1'b1;
  assign below_addr = (scan_row == LAST_ROW) ? '0 : scan_row + 1'b1;
  assign raw_above  = (WRAP == 0 && scan_row == '0) ? '0 : rd_a[cur_sel];
  assign raw_below  = (WRAP == 0 && scan_row == LAST_ROW) ? '0 : rd_b[cur_sel];

  assign bus.win_above = (WIDTH+2)'(guard_row(MAX_WIDTH'(raw_above), WIDTH, WRAP != 0));
  assign bus.win_cur   = (WIDTH+2)'(guard_row(MAX_WIDTH'(rd_c[cur_sel]), WIDTH, WRAP != 0));
  assign bus.win_below = (WIDTH+2)'(guard_row(MAX_WIDTH'(raw_below), WIDTH, WRAP != 0));

  assign bus.win_valid = (state == SCAN);
  assign bus.win_row   = scan_row;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == SWAP);
  assign bus.gen_count = gen_cnt;

endmodule
